// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with a per-register pending-write scoreboard.
// Optional same-cycle write-through bypass selected by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = $clog2(NREGS),
  parameter int NRD     = 2,
  parameter int PW      = 2,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ready,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  localparam logic [PW-1:0] PEND_MAX = '1;
  localparam logic [PW-1:0] PEND_ONE = PW'(1);

  logic [XLEN-1:0] regs [NREGS];
  logic [PW-1:0]   pend [NREGS];

  logic rsv_is_r0;
  logic wr_is_r0;
  logic rsv_fire;

  assign rsv_is_r0 = R0_ZERO && (rsv_addr == '0);
  assign wr_is_r0  = R0_ZERO && (wr_addr == '0);

  // Reservation handshake: a reservation transfers on a rising clk edge only when
  // rsv_valid and rsv_ready are both high; rsv_ready never depends on rsv_valid.
  // A full counter still accepts when a writeback to the same register frees a slot.
  assign rsv_ready = (pend[rsv_addr] != PEND_MAX) || (we && (wr_addr == rsv_addr)) ||
                     flush || rsv_is_r0;
  assign rsv_fire  = rsv_valid && rsv_ready && !rsv_is_r0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
    end else begin
      if (we && !wr_is_r0) begin
        regs[wr_addr] <= wr_data;
      end
      for (int r = 0; r < NREGS; r++) begin
        logic inc;
        logic dec;
        inc = rsv_fire && (rsv_addr == AW'(r));
        dec = we && (wr_addr == AW'(r)) && (pend[r] != '0);
        if (flush) begin
          pend[r] <= inc ? PEND_ONE : '0;
        end else if (inc && !dec) begin
          pend[r] <= pend[r] + PEND_ONE;
        end else if (dec && !inc) begin
          pend[r] <= pend[r] - PEND_ONE;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic          rd_is_r0;
      a        = rd_addr[i*AW +: AW];
      rd_is_r0 = R0_ZERO && (a == '0);
      rd_data[i*XLEN +: XLEN] = rd_is_r0 ? '0 : regs[a];
`ifdef REGFILE_BYPASS_EN
      if (we && (wr_addr == a) && !rd_is_r0) begin
        rd_data[i*XLEN +: XLEN] = wr_data;
      end
      // The last outstanding writeback clears busy in the same cycle it lands.
      rd_busy[i] = (pend[a] != '0) && !((pend[a] == PEND_ONE) && we && (wr_addr == a));
`else
      rd_busy[i] = (pend[a] != '0);
`endif
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_vec[r] = (pend[r] != '0);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized + directed bench for regfile_scoreboard against an array-based model.
// Expectations follow REGFILE_BYPASS_EN if the bench is built with it defined.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int PMAX = 3;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                we;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ready;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  int              m_pend [NREGS];

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_valid(rsv_valid),
    .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .flush(flush), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return (rsv_addr == 0) || (m_pend[rsv_addr] != PMAX) ||
           (we && (wr_addr == rsv_addr)) || flush;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && (wr_addr == a)) return wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a);
`ifdef REGFILE_BYPASS_EN
    int d;
    d = (we && (wr_addr == a) && m_pend[a] > 0) ? 1 : 0;
    return (m_pend[a] - d) != 0;
`else
    return m_pend[a] != 0;
`endif
  endfunction

  task automatic check_outputs();
    logic [NRD*XLEN-1:0] ed;
    logic [NRD-1:0]      eb;
    logic [NREGS-1:0]    ev;
    for (int i = 0; i < NRD; i++) begin
      ed[i*XLEN +: XLEN] = exp_rd(int'(rd_addr[i*AW +: AW]));
      eb[i] = exp_busy(int'(rd_addr[i*AW +: AW]));
    end
    for (int r = 0; r < NREGS; r++) ev[r] = (m_pend[r] != 0);
    check("rd_data", 64'(rd_data), 64'(ed));
    check("rd_busy", 64'(rd_busy), 64'(eb));
    check("busy_vec", 64'(busy_vec), 64'(ev));
    check("rsv_ready", 64'(rsv_ready), 64'(exp_ready()));
  endtask

  task automatic model_update();
    bit acc;
    acc = rsv_valid && exp_ready() && (rsv_addr != 0);
    for (int r = 0; r < NREGS; r++) begin
      int inc;
      int dec;
      inc = (acc && rsv_addr == r) ? 1 : 0;
      dec = (we && wr_addr == r && m_pend[r] > 0) ? 1 : 0;
      if (flush) m_pend[r] = inc;
      else m_pend[r] = m_pend[r] + inc - dec;
    end
    if (we && wr_addr != 0) m_regs[wr_addr] = wr_data;
  endtask

  task automatic set_idle();
    we = 0; wr_addr = '0; wr_data = '0;
    rsv_valid = 0; rsv_addr = '0; flush = 0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  // Inputs are set at the falling edge; compare, advance model, take the rising edge.
  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 0;
    end
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("reset_ready", 64'(rsv_ready), 64'd1);
    check("reset_busy_vec", 64'(busy_vec), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    set_rd(0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check("por_busy_vec", 64'(busy_vec), 64'd0);
    check("por_ready", 64'(rsv_ready), 64'd1);
    check("por_rd_data", 64'(rd_data), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Write x5, read back; write x0 reads zero.
    set_rd(5, 0); we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; step();
    set_idle(); step();
    check("x5_read", 64'(rd_data[31:0]), 64'hDEADBEEF);
    we = 1; wr_addr = 0; wr_data = 32'h1234; set_rd(0, 5); step();
    set_idle(); step();
    check("x0_zero", 64'(rd_data[31:0]), 64'd0);

    // Saturate x7, then write+reserve in the same cycle.
    set_rd(7, 5);
    repeat (3) begin rsv_valid = 1; rsv_addr = 7; step(); end
    #1; check("x7_full_ready", 64'(rsv_ready), 64'd0);
    step();
    we = 1; wr_addr = 7; wr_data = 32'h77; rsv_valid = 1; rsv_addr = 7;
    #1; check("x7_wr_rsv_ready", 64'(rsv_ready), 64'd1);
    step();
    set_idle(); rsv_addr = 7;
    #1; check("x7_still_full", 64'(rsv_ready), 64'd0);
    check("x7_busy", 64'(busy_vec[7]), 64'd1);
    step();
    repeat (3) begin set_idle(); we = 1; wr_addr = 7; wr_data = $urandom; step(); end
    set_idle();
    #1; check("x7_drained", 64'(busy_vec[7]), 64'd0);

    // Reserve x3, then write it back.
    set_rd(3, 7); rsv_valid = 1; rsv_addr = 3; step();
    set_idle(); we = 1; wr_addr = 3; wr_data = 32'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x3_bypass_data", 64'(rd_data[31:0]), 64'h55);
    check("x3_bypass_busy", 64'(rd_busy[0]), 64'd0);
`else
    check("x3_old_data", 64'(rd_data[31:0]), 64'd0);
    check("x3_old_busy", 64'(rd_busy[0]), 64'd1);
`endif
    step();
    set_idle();
    #1;
    check("x3_new_data", 64'(rd_data[31:0]), 64'h55);
    check("x3_new_busy", 64'(rd_busy[0]), 64'd0);
    step();

    // Flush with a same-cycle reservation of x4.
    repeat (2) begin rsv_valid = 1; rsv_addr = 9; step(); end
    rsv_valid = 1; rsv_addr = 4; step();
    set_idle(); flush = 1; rsv_valid = 1; rsv_addr = 4; step();
    set_idle();
    #1; check("flush_busy_vec", 64'(busy_vec), 64'h10);
    step();
    rsv_valid = 1; rsv_addr = 4; step();
    set_idle(); rsv_addr = 4;
    #1; check("x4_pend2_ready", 64'(rsv_ready), 64'd1);
    step();
    repeat (2) begin set_idle(); we = 1; wr_addr = 4; step(); end

    // Unreserved write to x10.
    set_idle(); set_rd(10, 10); we = 1; wr_addr = 10; wr_data = 32'hA5A5F00D; step();
    set_idle();
    #1;
    check("x10_data", 64'(rd_data[31:0]), 64'hA5A5F00D);
    check("x10_not_busy", 64'(busy_vec[10]), 64'd0);
    step();

    // Reset after activity.
    rsv_valid = 1; rsv_addr = 12; step();
    set_idle(); set_rd(5, 10); rsv_addr = 12;
    mid_reset();

    // Randomized traffic on a narrow address window to reach saturation often.
    for (int n = 0; n < 400; n++) begin
      set_idle();
      set_rd($urandom_range(0, 7), $urandom_range(0, 31));
      we        = ($urandom_range(0, 2) == 0);
      wr_addr   = AW'($urandom_range(0, 7));
      wr_data   = $urandom;
      rsv_valid = ($urandom_range(0, 1) == 1);
      rsv_addr  = AW'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 30) == 0);
      if (n == 200) mid_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
